// File: rtl/uart_rx_framed.sv
// Oversampled UART receiver: 2-flop synchroniser, optional parity, 1-2 stop bits, valid/accept output with error flags.
// Optional macro UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote over the ticks around its centre.
module uart_rx_framed #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk_50MHz,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_accept,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_AT = OVERSAMPLE / 2;
`else
    localparam int SAMPLE_AT = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_AT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic             ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d, rxs_q, rxs_d;
    logic                 armed_q, armed_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 zero_q, zero_d;
    logic                 perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d, brk_acc_q, brk_acc_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d, parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;
    logic                 break_det_q, break_det_d;
    logic                 bit_now, sample_now, complete, ferr_now, brk_now;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]           hist_q, hist_d;
`endif

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        rx_meta_d     = rx;
        rxs_d         = rx_meta_q;
        state_d       = state_q;
        armed_d       = armed_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        stop_cnt_d    = stop_cnt_q;
        shreg_d       = shreg_q;
        zero_d        = zero_q;
        perr_acc_d    = perr_acc_q;
        ferr_acc_d    = ferr_acc_q;
        brk_acc_d     = brk_acc_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        parity_err_d  = parity_err_q;
        frame_err_d   = frame_err_q;
        overrun_err_d = 1'b0;
        break_det_d   = 1'b0;
        complete      = 1'b0;
        ferr_now      = ferr_acc_q;
        brk_now       = brk_acc_q;
`ifdef UART_RX_MAJORITY_EN
        hist_d = hist_q;
        if (sample_tick) hist_d = {hist_q[0], rxs_q};
        // hist_q holds the mid-1 and mid samples when the vote is taken at mid+1.
        bit_now = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
        bit_now = rxs_q;
`endif
        sample_now = sample_tick && (tick_cnt_q == CNT_SAMPLE);
        if (sample_tick) tick_cnt_d = (tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                if (rxs_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d    = S_START;
                    armed_d    = 1'b0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    zero_d     = 1'b1;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                    brk_acc_d  = 1'b0;
                end
            end
            S_START: if (sample_now) state_d = bit_now ? S_IDLE : S_DATA;
            S_DATA: if (sample_now) begin
                shreg_d = {bit_now, shreg_q[DATA_BITS-1:1]};
                zero_d  = zero_q & ~bit_now;
                if (bit_cnt_q == BIT_LAST) state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                else bit_cnt_d = bit_cnt_q + 1'b1;
            end
            S_PARITY: if (sample_now) begin
                perr_acc_d = bit_now ^ (^shreg_q) ^ ODD_PARITY;
                zero_d     = zero_q & ~bit_now;
                state_d    = S_STOP;
            end
            S_STOP: if (sample_now) begin
                ferr_now = ferr_acc_q | ~bit_now;
                if (!stop_cnt_q && zero_q && !bit_now) brk_now = 1'b1;
                ferr_acc_d = ferr_now;
                brk_acc_d  = brk_now;
                if (stop_cnt_q == STOP_LAST) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A completing frame is kept only if the slot is free or being emptied this cycle.
        if (complete) begin
            break_det_d = brk_now;
            if (!data_valid_q || data_accept) begin
                data_out_d   = shreg_q;
                parity_err_d = perr_acc_q;
                frame_err_d  = ferr_now;
                data_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end else if (data_accept) begin
            data_valid_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            rx_meta_q     <= 1'b0;
            rxs_q         <= 1'b0;
            armed_q       <= 1'b0;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            stop_cnt_q    <= 1'b0;
            shreg_q       <= '0;
            zero_q        <= 1'b0;
            perr_acc_q    <= 1'b0;
            ferr_acc_q    <= 1'b0;
            brk_acc_q     <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            break_det_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rxs_q         <= rxs_d;
            armed_q       <= armed_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            stop_cnt_q    <= stop_cnt_d;
            shreg_q       <= shreg_d;
            zero_q        <= zero_d;
            perr_acc_q    <= perr_acc_d;
            ferr_acc_q    <= ferr_acc_d;
            brk_acc_q     <= brk_acc_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            break_det_q   <= break_det_d;
`ifdef UART_RX_MAJORITY_EN
            hist_q        <= hist_d;
`endif
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign break_det   = break_det_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: an 8N1 instance and an 8E1 instance, four clocks per sample_tick.
module tb_uart_rx_framed;
`ifdef UART_RX_MAJORITY_EN
    localparam int         MAJ        = 1;
    localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
    localparam int         MAJ        = 0;
    localparam logic [7:0] GLITCH_EXP = 8'hF7;
`endif
    // Completing tick counted from the start-bit drive: start centre at tick 8, then 16 ticks per bit.
    localparam int DONE_8N1 = 8 + 16 * 9 + MAJ;
    localparam int DONE_8E1 = 8 + 16 * 10 + MAJ;

    logic       clk_50MHz = 1'b0;
    logic       reset_n = 1'b0, rx = 1'b1, rx_p = 1'b1, sample_tick = 1'b0;
    logic       acc0 = 1'b0, acc_p = 1'b0;
    logic [7:0] d0, dp;
    logic       dv0, pe0, fe0, oe0, bd0, dvp, pep, fep, oep, bdp;
    int         checks = 0, errors = 0, ovr_cnt = 0, brk_cnt = 0;
    logic       dv_pre, dv_post;

    typedef struct {
        bit         to_p;
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         glitch;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;
    vec_t vecs[6];

    uart_rx_framed u_dut (
        .clk_50MHz(clk_50MHz), .reset_n(reset_n), .rx(rx), .sample_tick(sample_tick),
        .data_out(d0), .data_valid(dv0), .data_accept(acc0), .parity_err(pe0),
        .frame_err(fe0), .overrun_err(oe0), .break_det(bd0));

    uart_rx_framed #(.PARITY_MODE(1)) u_dut_par (
        .clk_50MHz(clk_50MHz), .reset_n(reset_n), .rx(rx_p), .sample_tick(sample_tick),
        .data_out(dp), .data_valid(dvp), .data_accept(acc_p), .parity_err(pep),
        .frame_err(fep), .overrun_err(oep), .break_det(bdp));

    always #10 clk_50MHz = ~clk_50MHz;

    initial begin
        int div = 0;
        forever begin
            @(posedge clk_50MHz);
            #1;
            div = (div + 1) % 4;
            sample_tick = (div == 0);
        end
    end

    always @(negedge clk_50MHz) begin
        if (oe0) ovr_cnt <= ovr_cnt + 1;
        if (bd0) brk_cnt <= brk_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the caller at the negedge just after a tick edge (tick T0).
    task automatic align();
        do @(negedge clk_50MHz); while (!sample_tick);
        @(negedge clk_50MHz);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) align();
    endtask

    task automatic send_frame(input bit to_p, input logic [15:0] bits, input int nbits,
                              input int glitch_k, input int done_t, input bit acc_at_done);
        logic v;
        align();
        for (int k = 0; k < nbits * 16; k++) begin
            if (k == done_t - 1) dv_pre = to_p ? dvp : dv0;
            if (k == done_t) dv_post = to_p ? dvp : dv0;
            v = (k == glitch_k) ? 1'b0 : bits[k / 16];
            if (to_p) rx_p = v;
            else rx = v;
            do @(negedge clk_50MHz); while (!sample_tick);
            if (k + 1 == done_t && acc_at_done) begin
                if (to_p) acc_p = 1'b1;
                else acc0 = 1'b1;
            end
            @(negedge clk_50MHz);
            acc0 = 1'b0;
            acc_p = 1'b0;
        end
        rx = 1'b1;
        rx_p = 1'b1;
    endtask

    initial begin
        logic [15:0] bits;
        int          nb, brk0, ovr0;

        vecs[0] = '{1'b0, 8'h55, 1'b0, 1'b1, -1, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA3, 1'b1, 1'b1, -1, 8'hA3, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'hA3, 1'b0, 1'b1, -1, 8'hA3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, -1, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, -1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b1, 71, GLITCH_EXP, 1'b0, 1'b0, 1'b0};

        #5;
        check("reset data_out", d0, 0);
        check("reset data_valid", dv0, 0);
        check("reset parity_err", pe0, 0);
        check("reset frame_err", fe0, 0);
        check("reset overrun_err", oe0, 0);
        check("reset break_det", bd0, 0);
        repeat (3) @(negedge clk_50MHz);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_50MHz);

        // Four-tick low pulse: start centre sees high again.
        align();
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(40);
        check("false start data_valid", dv0, 0);

        for (int i = 0; i < 6; i++) begin
            bits = '0;
            if (vecs[i].to_p) begin
                bits[10:0] = {vecs[i].stop, vecs[i].par, vecs[i].data, 1'b0};
                nb = 11;
            end else begin
                bits[9:0] = {vecs[i].stop, vecs[i].data, 1'b0};
                nb = 10;
            end
            brk0 = brk_cnt;
            send_frame(vecs[i].to_p, bits, nb, vecs[i].glitch,
                       vecs[i].to_p ? DONE_8E1 : DONE_8N1, 1'b0);
            repeat (8) @(negedge clk_50MHz);
            check($sformatf("v%0d valid before done tick", i), dv_pre, 0);
            check($sformatf("v%0d valid after done tick", i), dv_post, 1);
            check($sformatf("v%0d data_out", i), vecs[i].to_p ? dp : d0, vecs[i].exp_data);
            check($sformatf("v%0d parity_err", i), vecs[i].to_p ? pep : pe0, vecs[i].exp_perr);
            check($sformatf("v%0d frame_err", i), vecs[i].to_p ? fep : fe0, vecs[i].exp_ferr);
            check($sformatf("v%0d break pulses", i), brk_cnt - brk0, vecs[i].exp_brk);
            if (vecs[i].to_p) acc_p = 1'b1;
            else acc0 = 1'b1;
            @(negedge clk_50MHz);
            acc0 = 1'b0;
            acc_p = 1'b0;
            check($sformatf("v%0d valid after accept", i), vecs[i].to_p ? dvp : dv0, 0);
            wait_ticks(4);
        end

        // Break frame, then the line stays low: no re-arm until it goes high.
        brk0 = brk_cnt;
        send_frame(1'b0, 16'h0000, 10, -1, DONE_8N1, 1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk_50MHz);
        check("break frame_err", fe0, 1);
        check("break pulse count", brk_cnt - brk0, 1);
        acc0 = 1'b1;
        @(negedge clk_50MHz);
        acc0 = 1'b0;
        wait_ticks(50);
        check("held-low line no frame", dv0, 0);
        rx = 1'b1;
        wait_ticks(8);
        send_frame(1'b0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, -1, DONE_8N1, 1'b0);
        repeat (8) @(negedge clk_50MHz);
        check("after break data_out", d0, 8'h5A);
        check("after break frame_err", fe0, 0);
        acc0 = 1'b1;
        @(negedge clk_50MHz);
        acc0 = 1'b0;
        wait_ticks(4);

        // Overrun: second frame dropped; then accept coinciding with completion.
        send_frame(1'b0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1, DONE_8N1, 1'b0);
        repeat (8) @(negedge clk_50MHz);
        check("ovr first data_out", d0, 8'h11);
        ovr0 = ovr_cnt;
        send_frame(1'b0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1, DONE_8N1, 1'b0);
        repeat (8) @(negedge clk_50MHz);
        check("ovr kept data_out", d0, 8'h11);
        check("ovr data_valid", dv0, 1);
        check("ovr pulse count", ovr_cnt - ovr0, 1);
        ovr0 = ovr_cnt;
        send_frame(1'b0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1, DONE_8N1, 1'b1);
        repeat (8) @(negedge clk_50MHz);
        check("accept-at-done data_out", d0, 8'h22);
        check("accept-at-done data_valid", dv0, 1);
        check("accept-at-done no overrun", ovr_cnt - ovr0, 0);

        // Reset in the middle of a data field; the frame held in data_out is dropped too.
        fork
            send_frame(1'b0, {6'b0, 1'b1, 8'h00, 1'b0}, 10, -1, -5, 1'b0);
            begin
                repeat (240) @(negedge clk_50MHz);
                #2 reset_n = 1'b0;
                #3;
                check("mid reset data_out", d0, 0);
                check("mid reset data_valid", dv0, 0);
                check("mid reset parity_err", pe0, 0);
                check("mid reset frame_err", fe0, 0);
                check("mid reset overrun_err", oe0, 0);
                check("mid reset break_det", bd0, 0);
                repeat (40) @(negedge clk_50MHz);
                reset_n = 1'b1;
            end
        join
        wait_ticks(8);
        check("partial frame discarded", dv0, 0);
        send_frame(1'b0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, -1, DONE_8N1, 1'b0);
        repeat (8) @(negedge clk_50MHz);
        check("post reset data_out", d0, 8'h81);
        check("post reset data_valid", dv0, 1);
        check("post reset frame_err", fe0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
